alu: RTL and testbench

//  Parameterised integer ALU: combinational result and NZCV-style flags from two operands and a 4-bit opcode.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_adder.sv | 39 +++
 rtl/alu.sv | 112 +++++++++++
 tb/tb_alu.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU: the 4-bit opcode map and the
// bit positions of the N/Z/C/V flags inside the packed flag vector.
// -----------------------------------------------------------------------------
package alu_pkg;

    // Opcode map (4 bits). Codes 4'hD..4'hF are reserved and produce y = 0.
    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOR   = 4'h5;
    localparam logic [3:0] OP_SLL   = 4'h6;
    localparam logic [3:0] OP_SRL   = 4'h7;
    localparam logic [3:0] OP_SRA   = 4'h8;
    localparam logic [3:0] OP_SLT   = 4'h9;
    localparam logic [3:0] OP_SLTU  = 4'hA;
    localparam logic [3:0] OP_PASSA = 4'hB;
    localparam logic [3:0] OP_PASSB = 4'hC;

    // Bit positions in the packed {N,Z,C,V} flag vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_adder.sv
// -----------------------------------------------------------------------------
// alu_adder
// (WIDTH+1)-bit adder/subtractor shared by ADD, SUB, SLT and SLTU.
// With sub = 1 it computes a + ~b + 1, so the carry out is the "no borrow"
// indication (1 when a >= b unsigned).
// Ports:
//   a, b      in   WIDTH  operands
//   sub       in   1      1: subtract (invert b, carry-in = 1)
//   sum       out  WIDTH  result
//   carry     out  1      carry-out of bit WIDTH-1
//   overflow  out  1      signed overflow of the operation performed
// -----------------------------------------------------------------------------
module alu_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum_ext;

    assign w_b_eff   = sub ? ~b : b;
    assign w_sum_ext = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, sub};

    assign sum   = w_sum_ext[WIDTH-1:0];
    assign carry = w_sum_ext[WIDTH];

    // Overflow when the two addends (after inversion for SUB) share a sign
    // and the result sign differs. For SUB this is exactly "a and b differ
    // in sign and the result sign differs from a".
    assign overflow = (a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                      (w_sum_ext[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Execute-stage integer ALU: combinational result and NZCV flags from two
// operands and a 4-bit opcode, plus a status register that captures the
// flags when flag_we is asserted.
// Ports:
//   clk       in   1      clock (status register only)
//   rst_n     in   1      asynchronous active-low reset
//   a         in   WIDTH  operand A
//   b         in   WIDTH  operand B; low $clog2(WIDTH) bits are the shift amount
//   op        in   4      opcode (see alu_pkg)
//   flag_we   in   1      load {N,Z,C,V} into flags_q at the next rising edge
//   y         out  WIDTH  result (combinational)
//   carry     out  1      C flag (combinational)
//   overflow  out  1      V flag (combinational)
//   zero      out  1      Z flag (combinational)
//   negative  out  1      N flag (combinational)
//   flags_q   out  4      registered {N,Z,C,V}
// -----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             flag_we,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic [3:0]       flags_q
);

    localparam int SHW = $clog2(WIDTH);

    logic             w_sub;
    logic [WIDTH-1:0] w_sum;
    logic             w_add_c;
    logic             w_add_v;
    logic [SHW-1:0]   w_sh;
    logic             w_slt;
    logic             w_sltu;
    logic [3:0]       r_flags;

    // SLT and SLTU reuse the subtractor, so every compare op drives sub.
    assign w_sub = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);

    alu_adder #(.WIDTH(WIDTH)) u_adder (
        .a        (a),
        .b        (b),
        .sub      (w_sub),
        .sum      (w_sum),
        .carry    (w_add_c),
        .overflow (w_add_v)
    );

    // Upper bits of b are deliberately ignored for shifts.
    assign w_sh = b[SHW-1:0];

    // Signed less-than is N xor V of a-b; unsigned less-than is a borrow.
    assign w_slt  = w_sum[WIDTH-1] ^ w_add_v;
    assign w_sltu = ~w_add_c;

    always_comb begin
        // NOTE: y gets a default before the case so every opcode, including
        // reserved ones, assigns it and no latch is inferred.
        y = '0;
        unique case (op)
            OP_ADD,
            OP_SUB:   y = w_sum;
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NOR:   y = ~(a | b);
            OP_SLL:   y = a << w_sh;
            OP_SRL:   y = a >> w_sh;
            OP_SRA:   y = $unsigned($signed(a) >>> w_sh);
            OP_SLT:   y = {{(WIDTH-1){1'b0}}, w_slt};
            OP_SLTU:  y = {{(WIDTH-1){1'b0}}, w_sltu};
            OP_PASSA: y = a;
            OP_PASSB: y = b;
            default:  y = '0;
        endcase
    end

    // C and V are only meaningful for ADD/SUB; forced low otherwise.
    assign carry    = ((op == OP_ADD) || (op == OP_SUB)) ? w_add_c : 1'b0;
    assign overflow = ((op == OP_ADD) || (op == OP_SUB)) ? w_add_v : 1'b0;
    assign zero     = (y == '0);
    assign negative = y[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else if (flag_we) begin
            // NOTE: non-blocking assignment for clocked state so every
            // register samples its inputs from before the edge.
            r_flags[FLAG_N] <= negative;
            r_flags[FLAG_Z] <= zero;
            r_flags[FLAG_C] <= carry;
            r_flags[FLAG_V] <= overflow;
        end
    end

    assign flags_q = r_flags;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
// Directed self-checking bench for alu (WIDTH = 32).
// -----------------------------------------------------------------------------
module tb_alu;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             flag_we;
    logic [WIDTH-1:0] y;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic [3:0]       flags_q;

    int n_tests = 0;
    int n_fail  = 0;

    alu #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .op       (op),
        .flag_we  (flag_we),
        .y        (y),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative),
        .flags_q  (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one vector, let it settle, then compare y and {N,Z,C,V}.
    task automatic vec(input string tag, input logic [3:0] o,
                       input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] ey, input logic [3:0] enzcv);
        op = o;
        a  = va;
        b  = vb;
        #2;
        check({tag, ".y"}, y, ey);
        check({tag, ".nzcv"}, {28'd0, negative, zero, carry, overflow}, {28'd0, enzcv});
    endtask

    initial begin
        rst_n   = 1'b0;
        flag_we = 1'b0;
        op      = OP_ADD;
        a       = '0;
        b       = '0;
        #3;
        check("reset_flags_q", {28'd0, flags_q}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Logic ops                  op        a             b             y             NZCV
        vec("and",      OP_AND,   32'hF0F00000, 32'h0FF0F0FF, 32'h00F00000, 4'b0000);
        vec("or",       OP_OR,    32'h00F000F0, 32'h0F0F0000, 32'h0FFF00F0, 4'b0000);
        vec("xor",      OP_XOR,   32'hFFFF0000, 32'h00FFFFFF, 32'hFF00FFFF, 4'b1000);
        vec("nor",      OP_NOR,   32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 4'b0100);
        vec("and_zero", OP_AND,   32'h00000000, 32'hFFFFFFFF, 32'h00000000, 4'b0100);
        vec("or_neg",   OP_OR,    32'h80000000, 32'h00000000, 32'h80000000, 4'b1000);

        // Arithmetic
        vec("add_wrap", OP_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110);
        vec("add_ovf",  OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001);
        vec("add_pl",   OP_ADD,   32'h00001234, 32'h00004321, 32'h00005555, 4'b0000);
        vec("sub_brw",  OP_SUB,   32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000);
        vec("sub_ovf",  OP_SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011);
        vec("sub_eq",   OP_SUB,   32'h00000005, 32'h00000005, 32'h00000000, 4'b0110);

        // Shifts (upper bits of b ignored)
        vec("sll31",    OP_SLL,   32'h00000001, 32'h0000001F, 32'h80000000, 4'b1000);
        vec("sra4",     OP_SRA,   32'h80000000, 32'h00000004, 32'hF8000000, 4'b1000);
        vec("srl4",     OP_SRL,   32'h80000000, 32'h00000004, 32'h08000000, 4'b0000);
        vec("sra_hib",  OP_SRA,   32'h80000000, 32'hFFFFFF04, 32'hF8000000, 4'b1000);
        vec("sll_sh0",  OP_SLL,   32'h12345678, 32'h00000020, 32'h12345678, 4'b0000);
        vec("srl_sh0",  OP_SRL,   32'h87654321, 32'h00000020, 32'h87654321, 4'b1000);

        // Compares
        vec("slt_m1",   OP_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000);
        vec("sltu_m1",  OP_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0100);
        vec("slt_rev",  OP_SLT,   32'h00000001, 32'hFFFFFFFF, 32'h00000000, 4'b0100);
        vec("sltu_rev", OP_SLTU,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, 4'b0000);
        vec("slt_ovf",  OP_SLT,   32'h80000000, 32'h00000001, 32'h00000001, 4'b0000);

        // Pass-through and reserved
        vec("passa",    OP_PASSA, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 4'b1000);
        vec("passb",    OP_PASSB, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 4'b0100);
        vec("rsvd_f",   4'hF,     32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0100);
        vec("rsvd_d",   4'hD,     32'h7FFFFFFF, 32'h00000001, 32'h00000000, 4'b0100);

        // flag_we was low throughout: status register still at reset value
        check("flags_idle", {28'd0, flags_q}, 32'd0);

        // Load a nonzero value, then reset mid-cycle without a clock edge
        @(negedge clk);
        vec("ld1", OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110);
        flag_we = 1'b1;
        @(posedge clk); #1;
        flag_we = 1'b0;
        check("flags_ld1", {28'd0, flags_q}, 32'h6);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("flags_async_rst", {28'd0, flags_q}, 32'd0);

        // Release, load ADD 7FFFFFFF+1 -> {N,Z,C,V} = 1001
        @(negedge clk);
        rst_n = 1'b1;
        vec("ld2", OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001);
        flag_we = 1'b1;
        @(posedge clk); #1;
        check("flags_ld2", {28'd0, flags_q}, 32'h9);

        // flag_we low: new ops must not disturb the captured flags
        flag_we = 1'b0;
        vec("hold_op1", OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110);
        @(posedge clk); #1;
        vec("hold_op2", OP_XOR, 32'hFFFF0000, 32'h00FFFFFF, 32'hFF00FFFF, 4'b1000);
        @(posedge clk); #1;
        check("flags_hold", {28'd0, flags_q}, 32'h9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
